// File: rtl/hall_emu_pkg.sv
// -----------------------------------------------------------------------------
// hall_emu_pkg
//   Shared definitions for the hall sensor emulator: the six valid hall codes,
//   the forward commutation table, the step-state encoding and helpers that
//   walk the table in either direction.
//   The optional fault-injection feature (macro HALL_EMU_FAULT_EN) uses
//   HALL_INVALID as the substituted code.
// -----------------------------------------------------------------------------
package hall_emu_pkg;

  localparam logic [2:0] HALL_A = 3'b101;
  localparam logic [2:0] HALL_B = 3'b100;
  localparam logic [2:0] HALL_C = 3'b110;
  localparam logic [2:0] HALL_D = 3'b010;
  localparam logic [2:0] HALL_E = 3'b011;
  localparam logic [2:0] HALL_F = 3'b001;

  localparam int NUM_STEPS = 6;
  localparam logic [2:0] HALL_INVALID = 3'b000;

  // Element 0 is the rightmost entry, so HALL_SEQ[i] is the code of step i.
  localparam logic [NUM_STEPS-1:0][2:0] HALL_SEQ =
    {HALL_F, HALL_E, HALL_D, HALL_C, HALL_B, HALL_A};

  // Step state doubles as the step index 0..5.
  typedef enum logic [2:0] {
    STEP_0 = 3'd0,
    STEP_1 = 3'd1,
    STEP_2 = 3'd2,
    STEP_3 = 3'd3,
    STEP_4 = 3'd4,
    STEP_5 = 3'd5
  } step_t;

  // Adjacent step in the requested direction (0 = forward, 1 = reverse).
  // Unused encodings 6/7 recover to STEP_0.
  function automatic step_t step_neighbour(input step_t cur, input logic dir);
    step_t nxt;
    if (cur > STEP_5) begin
      nxt = STEP_0;
    end else if (!dir) begin
      nxt = (cur == STEP_5) ? STEP_0 : step_t'(cur + 3'd1);
    end else begin
      nxt = (cur == STEP_0) ? STEP_5 : step_t'(cur - 3'd1);
    end
    return nxt;
  endfunction

  // Hall code for a step; unused encodings map to the step 0 code.
  function automatic logic [2:0] hall_code(input step_t s);
    logic [2:0] code;
    if (s > STEP_5) begin
      code = HALL_A;
    end else begin
      code = HALL_SEQ[s];
    end
    return code;
  endfunction

endpackage

// File: rtl/hall_step_timer.sv
// -----------------------------------------------------------------------------
// hall_step_timer
//   Step timer for the hall emulator. Clamps the requested period up to
//   MIN_PERIOD, holds it in a shadow register that reloads only at a step
//   boundary (and in reset), and raises terminal in the last clock of a step.
//
// Ports
//   clock     in   system clock, posedge
//   reset     in   synchronous, active-high; clears the count, loads period
//   enable    in   1 = count, 0 = hold the current count
//   period    in   CNT_W requested clocks per step
//   terminal  out  1 while enable=1 and the count is in its last clock
// -----------------------------------------------------------------------------
module hall_step_timer #(
  parameter int CNT_W      = 24,
  parameter int MIN_PERIOD = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] timer_reg;
  logic [CNT_W-1:0] period_l_reg;
  logic [CNT_W-1:0] period_clamped;

  assign period_clamped = (period < MIN_P) ? MIN_P : period;

  // ">=" rather than "==" keeps the count bounded even if the timer were ever
  // found beyond the shadow period; in normal operation they are equivalent.
  assign terminal = enable && (timer_reg >= (period_l_reg - ONE));

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_reg    <= '0;
      period_l_reg <= period_clamped;
    end else if (terminal) begin
      timer_reg    <= '0;
      period_l_reg <= period_clamped;
    end else if (enable) begin
      timer_reg    <= timer_reg + ONE;
    end
  end

endmodule

// File: rtl/hall_sensor_emulator.sv
// -----------------------------------------------------------------------------
// hall_sensor_emulator
//   Emulates the 3-bit hall code of a rotating BLDC motor. One hall change per
//   programmed step period, walking the commutation table forward or in
//   reverse. Period and direction are taken at each step boundary, so changes
//   apply from the next step.
//
//   Optional feature, macro HALL_EMU_FAULT_EN: adds the fault_inject input.
//   When fault_inject is high at a step boundary, the step entered there shows
//   HALL_INVALID (000) instead of its code; index and strobes are unaffected.
//
// Ports
//   clock         in   system clock, posedge
//   reset         in   synchronous, active-high, priority over all inputs
//   enable        in   1 = run, 0 = freeze timer and hall code
//   direction     in   0 = forward, 1 = reverse
//   period        in   CNT_W clocks per hall step (clamped to MIN_PERIOD)
//   fault_inject  in   only with HALL_EMU_FAULT_EN
//   hall_out      out  3 registered hall code
//   step_index    out  3 registered step 0..5
//   step_pulse    out  strobe in the cycle hall_out takes a new value
//   rev_pulse     out  strobe on the 5->0 (fwd) or 0->5 (rev) wrap
// -----------------------------------------------------------------------------
module hall_sensor_emulator
  import hall_emu_pkg::*;
#(
  parameter int CNT_W      = 24,
  parameter int MIN_PERIOD = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             direction,
  input  logic [CNT_W-1:0] period,
`ifdef HALL_EMU_FAULT_EN
  input  logic             fault_inject,
`endif
  output logic [2:0]       hall_out,
  output logic [2:0]       step_index,
  output logic             step_pulse,
  output logic             rev_pulse
);

  logic  terminal;

  step_t      state_reg, state_next;
  logic [2:0] hall_reg, hall_next;
  logic       step_pulse_reg, step_pulse_next;
  logic       rev_pulse_reg, rev_pulse_next;
  logic       dir_reg;

  hall_step_timer #(
    .CNT_W      (CNT_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .period   (period),
    .terminal (terminal)
  );

  // State, output and direction registers.
  // dir_reg is the direction latched at the previous boundary; it decides the
  // neighbour chosen at the coming boundary, where it reloads.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= STEP_0;
      hall_reg       <= HALL_A;
      step_pulse_reg <= 1'b0;
      rev_pulse_reg  <= 1'b0;
      dir_reg        <= direction;
    end else begin
      state_reg      <= state_next;
      hall_reg       <= hall_next;
      step_pulse_reg <= step_pulse_next;
      rev_pulse_reg  <= rev_pulse_next;
      if (terminal) begin
        dir_reg <= direction;
      end
    end
  end

  // Next step and outputs. Outside a boundary everything holds and the
  // strobes fall back to 0, which also covers enable=0.
  always_comb begin
    state_next      = state_reg;
    hall_next       = hall_reg;
    step_pulse_next = 1'b0;
    rev_pulse_next  = 1'b0;
    if (terminal) begin
      state_next      = step_neighbour(state_reg, dir_reg);
      hall_next       = hall_code(state_next);
      step_pulse_next = 1'b1;
      rev_pulse_next  = dir_reg ? (state_reg == STEP_0) : (state_reg == STEP_5);
`ifdef HALL_EMU_FAULT_EN
      if (fault_inject) begin
        hall_next = HALL_INVALID;
      end
`endif
    end
  end

  assign hall_out   = hall_reg;
  assign step_index = state_reg;
  assign step_pulse = step_pulse_reg;
  assign rev_pulse  = rev_pulse_reg;

endmodule
